// File: rtl/npu_sched_pkg.sv
// ---------------------------------------------------------------------------
// npu_sched_pkg
// Shared types for the NPU job scheduler: FSM state encoding, the job
// descriptor record and the default field widths used by the scheduler.
// ---------------------------------------------------------------------------
package npu_sched_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int LEN_W_DEF      = 8;
    localparam int ACC_WIDTH_DEF  = 20;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DRAIN   = 3'd2,
        WAIT_PE = 3'd3,
        RESP    = 3'd4
    } sched_state_e;

    // Job descriptor at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]    feat_base;
        logic [ADDR_W_DEF-1:0]    w_base;
        logic [LEN_W_DEF-1:0]     len;
        logic [ACC_WIDTH_DEF-1:0] bias;
    } job_desc_t;

endpackage

// File: rtl/npu_valid_delay.sv
// ---------------------------------------------------------------------------
// npu_valid_delay
// DEPTH-stage shift register carrying the {valid,last} issue strobes so the
// PE sees them in the same cycle as the synchronous RAM read data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_last     strobes from the address issue stage
//   out_valid, out_last   strobes delayed by exactly DEPTH cycles
// ---------------------------------------------------------------------------
module npu_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] last_r;

    generate
        if (DEPTH > 1) begin : g_multi
            // Shift both strobes one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_r <= {DEPTH{1'b0}};
                    last_r  <= {DEPTH{1'b0}};
                end else begin
                    valid_r <= {valid_r[DEPTH-2:0], in_valid};
                    last_r  <= {last_r[DEPTH-2:0], in_last};
                end
            end
        end else begin : g_single
            // Single stage: plain register of the strobes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end else begin
                    valid_r <= in_valid;
                    last_r  <= in_last;
                end
            end
        end
    endgenerate

    assign out_valid = valid_r[DEPTH-1];
    assign out_last  = last_r[DEPTH-1];

endmodule

// File: rtl/npu_job_scheduler.sv
// ---------------------------------------------------------------------------
// npu_job_scheduler
// Runs one dot-product job at a time: accepts a descriptor, walks feature and
// weight RAM addresses, drives PE valid/last/bias aligned to the RAM read
// latency, waits (bounded) for the PE result and returns it as a response.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*          descriptor handshake and fields
//   feat_addr, w_addr                   RAM read addresses
//   pe_valid, pe_last, pe_bias          PE input controls
//   pe_o_valid, pe_o_result             PE result
//   rsp_valid/rsp_ready, rsp_result,
//   rsp_err                             response handshake and payload
//   busy                                scheduler not idle
// ---------------------------------------------------------------------------
module npu_job_scheduler
    import npu_sched_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RAM_LAT    = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_feat_base,
    input  logic [ADDR_W-1:0]     cmd_w_base,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [ACC_WIDTH-1:0]  cmd_bias,
    output logic [ADDR_W-1:0]     feat_addr,
    output logic [ADDR_W-1:0]     w_addr,
    output logic                  pe_valid,
    output logic                  pe_last,
    output logic [ACC_WIDTH-1:0]  pe_bias,
    input  logic                  pe_o_valid,
    input  logic [DATA_WIDTH-1:0] pe_o_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_e          state_r, state_n;
    logic [ADDR_W-1:0]     feat_addr_r, w_addr_r;
    logic [LEN_W-1:0]      len_r, idx_r;
    logic [ACC_WIDTH-1:0]  bias_r;
    logic [CNT_W-1:0]      wait_cnt_r;
    logic [DATA_WIDTH-1:0] rsp_result_r;
    logic                  rsp_err_r, rsp_valid_r, cmd_ready_r, busy_r;
    logic                  accept_s, issue_s, issue_last_s, timeout_s;
    logic                  pe_valid_s, pe_last_s;

    // cmd_ready_r is high exactly when the state register holds IDLE.
    assign accept_s     = cmd_valid && cmd_ready_r;
    assign issue_s      = (state_r == ISSUE);
    assign issue_last_s = issue_s && (idx_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
    assign timeout_s    = (wait_cnt_r == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = (cmd_len == {LEN_W{1'b0}}) ? RESP : ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (issue_last_s) state_n = DRAIN;
                else              state_n = ISSUE;
            end
            // The final element leaving the delay line marks it empty.
            DRAIN: begin
                if (pe_last_s) state_n = WAIT_PE;
                else           state_n = DRAIN;
            end
            WAIT_PE: begin
                if (pe_o_valid || timeout_s) state_n = RESP;
                else                         state_n = WAIT_PE;
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
                else           state_n = RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: descriptor capture, address walk, wait counter, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_err_r    <= 1'b0;
            rsp_result_r <= {DATA_WIDTH{1'b0}};
            feat_addr_r  <= {ADDR_W{1'b0}};
            w_addr_r     <= {ADDR_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            idx_r        <= {LEN_W{1'b0}};
            bias_r       <= {ACC_WIDTH{1'b0}};
            wait_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            cmd_ready_r <= (state_n == IDLE);
            busy_r      <= (state_n != IDLE);
            rsp_valid_r <= (state_n == RESP);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        len_r        <= cmd_len;
                        bias_r       <= cmd_bias;
                        idx_r        <= {LEN_W{1'b0}};
                        wait_cnt_r   <= {CNT_W{1'b0}};
                        rsp_result_r <= {DATA_WIDTH{1'b0}};
                        rsp_err_r    <= (cmd_len == {LEN_W{1'b0}});
                        // A zero-length job leaves the RAM addresses untouched.
                        if (cmd_len != {LEN_W{1'b0}}) begin
                            feat_addr_r <= cmd_feat_base;
                            w_addr_r    <= cmd_w_base;
                        end
                    end
                end
                ISSUE: begin
                    // Addresses freeze on the last element; sums wrap naturally.
                    if (!issue_last_s) begin
                        idx_r       <= idx_r + {{(LEN_W-1){1'b0}}, 1'b1};
                        feat_addr_r <= feat_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        w_addr_r    <= w_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                WAIT_PE: begin
                    if (pe_o_valid) begin
                        rsp_result_r <= pe_o_result;
                        rsp_err_r    <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_result_r <= {DATA_WIDTH{1'b0}};
                        rsp_err_r    <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    npu_valid_delay #(
        .DEPTH (RAM_LAT)
    ) u_valid_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue_s),
        .in_last   (issue_last_s),
        .out_valid (pe_valid_s),
        .out_last  (pe_last_s)
    );

    assign cmd_ready  = cmd_ready_r;
    assign busy       = busy_r;
    assign feat_addr  = feat_addr_r;
    assign w_addr     = w_addr_r;
    assign pe_valid   = pe_valid_s;
    assign pe_last    = pe_last_s;
    assign pe_bias    = bias_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_npu_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_npu_job_scheduler
// Directed, table-driven bench for npu_job_scheduler. Two instances are
// built (RAM_LAT=1 and RAM_LAT=3); 'sel' routes commands to one of them.
// A small PE stand-in answers a fixed number of cycles after pe_last.
// ---------------------------------------------------------------------------
module tb_npu_job_scheduler;
    import npu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_feat_base = 8'h00, cmd_w_base = 8'h00, cmd_len = 8'h00;
    logic [19:0] cmd_bias = 20'h0;
    logic        pe_o_valid = 1'b0;
    logic [7:0]  pe_o_result = 8'h00;
    logic        rsp_ready = 1'b0;

    logic        cr1, pv1, pl1, rv1, re1, bz1;
    logic        cr3, pv3, pl3, rv3, re3, bz3;
    logic [7:0]  fa1, wa1, rr1, fa3, wa3, rr3;
    logic [19:0] pb1, pb3;

    logic        o_cmd_ready, o_pe_valid, o_pe_last, o_rsp_valid, o_rsp_err, o_busy;
    logic [7:0]  o_feat, o_w, o_rsp_result;
    logic [19:0] o_pe_bias;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    npu_job_scheduler #(.RAM_LAT(1), .TIMEOUT(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && !sel), .cmd_ready(cr1),
        .cmd_feat_base(cmd_feat_base), .cmd_w_base(cmd_w_base), .cmd_len(cmd_len),
        .cmd_bias(cmd_bias), .feat_addr(fa1), .w_addr(wa1), .pe_valid(pv1),
        .pe_last(pl1), .pe_bias(pb1), .pe_o_valid(pe_o_valid), .pe_o_result(pe_o_result),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_result(rr1), .rsp_err(re1), .busy(bz1)
    );

    npu_job_scheduler #(.RAM_LAT(3), .TIMEOUT(64)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && sel), .cmd_ready(cr3),
        .cmd_feat_base(cmd_feat_base), .cmd_w_base(cmd_w_base), .cmd_len(cmd_len),
        .cmd_bias(cmd_bias), .feat_addr(fa3), .w_addr(wa3), .pe_valid(pv3),
        .pe_last(pl3), .pe_bias(pb3), .pe_o_valid(pe_o_valid), .pe_o_result(pe_o_result),
        .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_result(rr3), .rsp_err(re3), .busy(bz3)
    );

    assign o_cmd_ready  = sel ? cr3 : cr1;
    assign o_feat       = sel ? fa3 : fa1;
    assign o_w          = sel ? wa3 : wa1;
    assign o_pe_valid   = sel ? pv3 : pv1;
    assign o_pe_last    = sel ? pl3 : pl1;
    assign o_pe_bias    = sel ? pb3 : pb1;
    assign o_rsp_valid  = sel ? rv3 : rv1;
    assign o_rsp_result = sel ? rr3 : rr1;
    assign o_rsp_err    = sel ? re3 : re1;
    assign o_busy       = sel ? bz3 : bz1;

    typedef struct {
        job_desc_t  desc;
        logic       sel;
        int         ram_lat;
        logic [7:0] pe_res;
        logic       mute;      // PE never answers
        int         pe_lat;    // cycles from pe_last to pe_o_valid
        int         hold;      // cycles rsp_ready stays low in RESP
        logic       exp_err;
        logic [7:0] exp_res;
        int         exp_rsp;   // cycle index (0 = first cycle after accept) of rsp_valid
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] fb, input logic [7:0] wb, input logic [7:0] len,
                                input logic [19:0] bias, input logic s, input int lat,
                                input logic [7:0] res, input logic mute, input int pl,
                                input int hold, input logic eerr, input logic [7:0] eres,
                                input int ecyc);
        vec_t v;
        v.desc.feat_base = fb;
        v.desc.w_base    = wb;
        v.desc.len       = len;
        v.desc.bias      = bias;
        v.sel = s; v.ram_lat = lat; v.pe_res = res; v.mute = mute; v.pe_lat = pl;
        v.hold = hold; v.exp_err = eerr; v.exp_res = eres; v.exp_rsp = ecyc;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int k_rsp, n_valid, first_v, last_v, n_last, k_last;
        logic [7:0] prev_feat, exp_a;
        int len;
        len = int'(v.desc.len);
        sel = v.sel;
        @(negedge clk);
        check("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);
        prev_feat = o_feat;
        cmd_feat_base = v.desc.feat_base;
        cmd_w_base    = v.desc.w_base;
        cmd_len       = v.desc.len;
        cmd_bias      = v.desc.bias;
        cmd_valid     = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        k_rsp = -1; n_valid = 0; first_v = -1; last_v = -1; n_last = 0; k_last = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            pe_o_valid = 1'b0;
            if (k == 0) check("pe_bias", 32'(o_pe_bias), 32'(v.desc.bias));
            if (k < len) begin
                exp_a = v.desc.feat_base + 8'(k);
                check("feat_addr", 32'(o_feat), 32'(exp_a));
                exp_a = v.desc.w_base + 8'(k);
                check("w_addr", 32'(o_w), 32'(exp_a));
            end
            if (o_pe_valid) begin
                n_valid++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            if (o_pe_last) begin
                n_last++;
                k_last = k;
            end
            if (o_rsp_valid) begin
                k_rsp = k;
                break;
            end
            if (!v.mute && k_last >= 0 && k == k_last + v.pe_lat) begin
                pe_o_valid  = 1'b1;
                pe_o_result = v.pe_res;
            end
        end
        check("rsp_cycle", 32'(k_rsp), 32'(v.exp_rsp));
        check("rsp_err", 32'(o_rsp_err), 32'(v.exp_err));
        check("rsp_result", 32'(o_rsp_result), 32'(v.exp_res));
        check("pe_valid_count", 32'(n_valid), 32'(len));
        check("pe_last_count", 32'(n_last), (len != 0) ? 32'd1 : 32'd0);
        check("busy_in_resp", 32'(o_busy), 32'd1);
        check("cmd_ready_in_resp", 32'(o_cmd_ready), 32'd0);
        if (len != 0) begin
            check("pe_valid_first", 32'(first_v), 32'(v.ram_lat));
            check("pe_valid_contig", 32'(last_v - first_v + 1), 32'(len));
            check("pe_last_pos", 32'(k_last), 32'(v.ram_lat + len - 1));
            exp_a = v.desc.feat_base + v.desc.len - 8'd1;
            check("feat_addr_hold", 32'(o_feat), 32'(exp_a));
        end else begin
            check("feat_addr_untouched", 32'(o_feat), 32'(prev_feat));
        end
        // Back-pressure: response must hold and a new command must be refused.
        if (v.hold > 0) begin
            cmd_feat_base = 8'hC0; cmd_w_base = 8'hD0; cmd_len = 8'd2; cmd_valid = 1'b1;
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
            check("hold_rsp_result", 32'(o_rsp_result), 32'(v.exp_res));
            check("hold_cmd_ready", 32'(o_cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("post_hs_cmd_ready", 32'(o_cmd_ready), 32'd1);
        check("post_hs_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("no_stray_accept", 32'(o_busy), 32'd0);
    endtask

    initial begin
        //            fb     wb     len    bias      sel lat res    mute pl hold err res    rsp
        vecs[0] = mk(8'h10, 8'h20, 8'd4, 20'd5,      1'b0, 1, 8'h2A, 1'b0, 2, 0, 1'b0, 8'h2A, 7);
        vecs[1] = mk(8'hFE, 8'hFF, 8'd4, 20'd7,      1'b0, 1, 8'h11, 1'b0, 1, 0, 1'b0, 8'h11, 6);
        vecs[2] = mk(8'h33, 8'h44, 8'd0, 20'd9,      1'b0, 1, 8'h77, 1'b0, 1, 0, 1'b1, 8'h00, 0);
        vecs[3] = mk(8'h30, 8'h40, 8'd3, 20'h12345,  1'b0, 1, 8'h5C, 1'b0, 3, 5, 1'b0, 8'h5C, 7);
        vecs[4] = mk(8'h00, 8'h80, 8'd2, 20'd3,      1'b0, 1, 8'h99, 1'b1, 1, 0, 1'b1, 8'h00, 67);
        vecs[5] = mk(8'h55, 8'hAA, 8'd1, 20'd1,      1'b0, 1, 8'hFF, 1'b0, 1, 0, 1'b0, 8'hFF, 3);
        vecs[6] = mk(8'h10, 8'h20, 8'd4, 20'd5,      1'b1, 3, 8'h2A, 1'b0, 2, 0, 1'b0, 8'h2A, 9);

        // Reset values on both instances.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
            check("rst_busy", 32'(o_busy), 32'd0);
            check("rst_pe_valid", 32'(o_pe_valid), 32'd0);
            check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
            check("rst_feat_addr", 32'(o_feat), 32'd0);
            check("rst_pe_bias", 32'(o_pe_bias), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of ISSUE of a len=8 job.
        sel = 1'b0;
        @(negedge clk);
        cmd_feat_base = 8'h60; cmd_w_base = 8'h70; cmd_len = 8'd8; cmd_bias = 20'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midjob_pe_valid", 32'(o_pe_valid), 32'd1);
        check("midjob_busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pe_valid", 32'(o_pe_valid), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(o_rsp_valid), 32'd0);
        end
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_job_scheduler.md
Name: npu_job_scheduler

Overview:
Sequences one dot-product job at a time on the NPU processing element. Accepts a job descriptor over a valid/ready command port and walks read addresses for the feature and weight RAMs. Drives the PE valid/last/bias inputs aligned to the synchronous RAM read latency, then captures the PE result and returns it over a valid/ready response port. Sits between the control unit (or a host queue) and the data memories plus PE.

Parameters:
ADDR_W, 8, RAM address width
LEN_W, 8, job length field width (elements)
ACC_WIDTH, 20, bias width, matches PE accumulator
DATA_WIDTH, 8, PE result width
RAM_LAT, 1, RAM read latency in cycles (1..4)
TIMEOUT, 64, max cycles waiting for PE result after last element

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  scheduler can accept descriptor
cmd_feat_base  in  ADDR_W  first feature address
cmd_w_base  in  ADDR_W  first weight address
cmd_len  in  LEN_W  element count
cmd_bias  in  ACC_WIDTH  bias for this job
feat_addr  out  ADDR_W  feature RAM read address
w_addr  out  ADDR_W  weight RAM read address
pe_valid  out  1  PE input valid, RAM data aligned
pe_last  out  1  final element of job
pe_bias  out  ACC_WIDTH  registered job bias, stable through job
pe_o_valid  in  1  PE result valid
pe_o_result  in  DATA_WIDTH  PE result
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_WIDTH  captured result
rsp_err  out  1  job failed (zero length or timeout)
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: cmd_ready=1, all other outputs 0, state IDLE, counters and delay pipeline cleared.
- Command handshake: transfer when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Descriptor fields are registered on transfer.
- States:
  - IDLE: on transfer, go to ISSUE if len!=0, else RESP with rsp_err=1 and rsp_result=0. No RAM/PE activity for a zero-length job.
  - ISSUE: one address pair per cycle. feat_addr=feat_base+i, w_addr=w_base+i, i=0..len-1. Sums wrap modulo 2^ADDR_W. On the cycle issuing i=len-1, go to DRAIN.
  - DRAIN: wait for the RAM_LAT delay pipeline to empty, then go to WAIT_PE.
  - WAIT_PE: count cycles. On pe_o_valid, capture pe_o_result, rsp_err=0, go to RESP. If the count reaches TIMEOUT, rsp_err=1, rsp_result=0, go to RESP.
  - RESP: rsp_valid=1, result held stable until rsp_ready. On the handshake, go to IDLE (cmd_ready=1 the next cycle).
- Alignment: issue strobe and last flag pass through a RAM_LAT-deep shift register.
  - pe_valid is asserted exactly RAM_LAT cycles after the corresponding address.
  - pe_last coincides with pe_valid of element len-1 only.
  - Exactly len pe_valid pulses per job, contiguous, no bubbles.
- Addresses hold their last value outside ISSUE.
- pe_o_valid outside WAIT_PE (including during DRAIN) is ignored.
- Throughput: job cycles = 1 (accept) + len + RAM_LAT + PE latency + response handshake. No overlap between jobs.
- Reset mid-operation: immediate return to reset values. pe_valid drops asynchronously and the in-flight job is discarded with no response.

Decomposition:
- Package npu_sched_pkg: state enum (IDLE, ISSUE, DRAIN, WAIT_PE, RESP), descriptor struct (feat_base, w_base, len, bias), default widths.
- Sub-module npu_valid_delay: parameterised RAM_LAT-deep shift register carrying {valid,last}, async active-low reset.

Test Plan:
1. feat_base=0x10, w_base=0x20, len=4, bias=5, RAM_LAT=1 -> addresses 10/20..13/23 on consecutive cycles; pe_valid high 4 cycles starting one cycle after the first address; pe_last on the 4th; PE returns 0x2A -> rsp_result=0x2A, rsp_err=0.
2. feat_base=0xFE, w_base=0xFF, len=4 -> feat_addr FE,FF,00,01; w_addr FF,00,01,02; exactly 4 pe_valid pulses.
3. len=0 -> no pe_valid; rsp_valid on the cycle after accept with rsp_err=1, rsp_result=0.
4. rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_result stable, cmd_ready=0, a new cmd_valid is not accepted until after the handshake.
5. PE never asserts pe_o_valid, TIMEOUT=64 -> rsp_err=1 exactly 64 cycles after entering WAIT_PE.
6. rst_n low during ISSUE of a len=8 job -> pe_valid/busy drop immediately, no response; the next job after reset runs normally. Repeat test 1 with RAM_LAT=3 -> pe_valid lags addresses by 3.
